// File: rtl/stream_unpack_pkg.sv
// Shared types and the generic left-streaming helper for stream_unpack_fifo.
package stream_unpack_pkg;

  localparam int unsigned MAX_W      = 64;
  localparam int unsigned IDX_W      = $clog2(MAX_W);
  localparam int unsigned FIELD_HI_W = 9;
  localparam int unsigned FIELD_LO_W = 7;

  typedef struct packed {
    logic [FIELD_HI_W-1:0] hi;
    logic [FIELD_LO_W-1:0] lo;
  } field_pair_t;

  // Equivalent of {<<s {word[w-1:0]}}: slice k (from the LSB) lands at MSB-side slot k,
  // a short remainder slice lands at the LSB end. Bits at and above w are returned as zero.
  function automatic logic [MAX_W-1:0] stream_rev(input logic [MAX_W-1:0] word,
                                                  input int unsigned w,
                                                  input int unsigned s);
    logic [MAX_W-1:0] res;
    int unsigned      k;
    int unsigned      wk;
    res = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        k  = i / s;
        wk = ((k + 1) * s <= w) ? s : w - k * s;
        res[IDX_W'((w + i) - (2 * k * s + wk))] = word[IDX_W'(i)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_unpack_xform.sv
// Combinational word-to-field-pair transform used on the FIFO push path.
module stream_unpack_xform
  import stream_unpack_pkg::*;
#(
  parameter int unsigned IN_W     = 32,
  parameter int unsigned SLICE    = 5,
  parameter int unsigned HI_W     = FIELD_HI_W,
  parameter int unsigned HI_SLICE = 3,
  parameter int unsigned LO_W     = FIELD_LO_W
) (
  input  logic [IN_W-1:0] in_data,
  output field_pair_t     pair
);

  localparam int unsigned T_W = HI_W + LO_W;

  logic [T_W-1:0]  t;
  logic [HI_W-1:0] h;

  // Keep the top T_W bits of the slice-reversed word; the rest is dropped.
  assign t = T_W'(stream_rev(MAX_W'(in_data), IN_W, SLICE) >> (IN_W - T_W));
  assign h = t[T_W-1 -: HI_W];

  assign pair.hi = HI_W'(stream_rev(MAX_W'(h), HI_W, HI_SLICE));
  assign pair.lo = t[LO_W-1:0];

endmodule

// File: rtl/stream_unpack_fifo.sv
// Valid/ready FIFO that stores unpacked field pairs of incoming words.
// Optional accepted-word counter port acc_cnt when STREAM_UNPACK_CNT_EN is defined.
module stream_unpack_fifo
  import stream_unpack_pkg::*;
#(
  parameter int unsigned IN_W     = 32,
  parameter int unsigned SLICE    = 5,
  parameter int unsigned HI_W     = FIELD_HI_W,
  parameter int unsigned HI_SLICE = 3,
  parameter int unsigned LO_W     = FIELD_LO_W,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [HI_W-1:0]          out_hi,
  output logic [LO_W-1:0]          out_lo,
  output logic [$clog2(DEPTH):0]   level
`ifdef STREAM_UNPACK_CNT_EN
  ,
  output logic [15:0]              acc_cnt
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  field_pair_t      mem [DEPTH];
  field_pair_t      wr_pair;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push, pop;

  stream_unpack_xform #(
    .IN_W    (IN_W),
    .SLICE   (SLICE),
    .HI_W    (HI_W),
    .HI_SLICE(HI_SLICE),
    .LO_W    (LO_W)
  ) u_xform (
    .in_data(in_data),
    .pair   (wr_pair)
  );

  assign in_ready  = (level_q != LVL_W'(DEPTH));
  assign out_valid = (level_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign level     = level_q;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_pair;
  end

  // Storage is not reset, so force zeros while empty.
  assign out_hi = out_valid ? mem[rd_ptr_q].hi : '0;
  assign out_lo = out_valid ? mem[rd_ptr_q].lo : '0;

`ifdef STREAM_UNPACK_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (push) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign acc_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_stream_unpack_fifo.sv
// Self-checking bench for stream_unpack_fifo: vector table, queue-based reference model,
// directed full/back-to-back/reset sequences and randomized traffic.
module tb_stream_unpack_fifo;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_hi;
  logic [6:0]  out_lo;
  logic [2:0]  level;
`ifdef STREAM_UNPACK_CNT_EN
  logic [15:0] acc_cnt;
`endif

  stream_unpack_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_hi   (out_hi),
    .out_lo   (out_lo),
    .level    (level)
`ifdef STREAM_UNPACK_CNT_EN
    ,
    .acc_cnt  (acc_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_q[$];
  logic [15:0] m_cnt;

  typedef struct {
    logic [31:0] din;
    logic [8:0]  hi;
    logic [6:0]  lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference transform written directly with the streaming operators.
  function automatic logic [15:0] ref_xform(input logic [31:0] d);
    logic [31:0] r;
    logic [8:0]  h;
    logic [8:0]  hr;
    logic [6:0]  lo;
    r  = {<<5{d}};
    h  = r[31:23];
    lo = r[22:16];
    hr = {<<3{h}};
    return {hr, lo};
  endfunction

  // Check outputs against the model, then advance one clock and update the model.
  task automatic cycle();
    logic        do_push;
    logic        do_pop;
    logic [15:0] head;
    chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("level", 32'(level), 32'(m_q.size()));
    if (m_q.size() != 0) begin
      head = m_q[0];
      chk("out_hi", 32'(out_hi), 32'(head[15:7]));
      chk("out_lo", 32'(out_lo), 32'(head[6:0]));
    end
`ifdef STREAM_UNPACK_CNT_EN
    chk("acc_cnt", 32'(acc_cnt), 32'(m_cnt));
`endif
    do_push = in_valid && (m_q.size() < DEPTH);
    do_pop  = out_ready && (m_q.size() != 0);
    @(posedge clk);
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back(ref_xform(in_data));
      m_cnt = m_cnt + 16'd1;
    end
    #1;
  endtask

  // Push one word into an empty FIFO, check the table values, then pop it.
  task automatic single(input logic [31:0] d, input logic [8:0] hi, input logic [6:0] lo,
                        input logic use_tbl);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    if (use_tbl) begin
      chk("tbl_hi", 32'(out_hi), 32'(hi));
      chk("tbl_lo", 32'(out_lo), 32'(lo));
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  vec_t vecs[5];
  int   guard;

  initial begin
    vecs[0] = '{32'h0000_0001, 9'h010, 7'h00};
    vecs[1] = '{32'h0000_0004, 9'h001, 7'h00};
    vecs[2] = '{32'h0000_0020, 9'h000, 7'h40};
    vecs[3] = '{32'h4000_0000, 9'h000, 7'h00};
    vecs[4] = '{32'h8000_0000, 9'h000, 7'h00};

    m_cnt     = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    #3;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_hi", 32'(out_hi), 32'd0);
    chk("rst_out_lo", 32'(out_lo), 32'd0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Known-answer table
    foreach (vecs[i]) single(vecs[i].din, vecs[i].hi, vecs[i].lo, 1'b1);

    // One-hot sweep against the model
    for (int i = 0; i < 32; i++) single(32'd1 << i, '0, '0, 1'b0);

    // Fill while stalled, then drain in order
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 32'h1111_1111 * (k + 1) + 32'h0123_4567;
      cycle();
    end
    in_data = 32'hDEAD_BEEF;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_level", 32'(level), 32'd4);
    cycle();
    cycle();
    chk("held_level", 32'(level), 32'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) cycle();
    chk("drained_level", 32'(level), 32'd0);

    // Back-to-back streaming
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_data = $urandom;
      cycle();
      chk("b2b_level", 32'(level), 32'd1);
      chk("b2b_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    cycle();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      cycle();
    end

    // Asynchronous reset with three entries queued
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (m_q.size() != 0) cycle();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = $urandom;
      cycle();
    end
    in_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_out_hi", 32'(out_hi), 32'd0);
`ifdef STREAM_UNPACK_CNT_EN
    chk("async_acc_cnt", 32'(acc_cnt), 32'd0);
`endif
    m_q.delete();
    m_cnt = '0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();

`ifdef STREAM_UNPACK_CNT_EN
    // Counter wrap: advance to 16'hFFFF, then one more push
    in_valid  = 1'b1;
    out_ready = 1'b1;
    guard     = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      in_data = $urandom;
      cycle();
      guard++;
    end
    chk("cnt_ffff", 32'(acc_cnt), 32'hFFFF);
    cycle();
    chk("cnt_wrap", 32'(acc_cnt), 32'd0);
    in_valid = 1'b0;
    cycle();
`else
    guard = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
